// File: rtl/stage_stream_feeder_pkg.sv
// Shared types and constants for the Stage_2head input-stream feeder.
// Imported by the feeder top level and its token buffer.
package stage_stream_feeder_pkg;

   localparam int att_width    = 16;
   localparam int FEED_DEPTH   = 16;
   localparam int FEED_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      WAIT_END,
      DONE
   } feeder_state_t;

endpackage

// File: rtl/stage_stream_feeder_buf.sv
// Token/bias register file for the feeder: one synchronous write port,
// one combinational read port, each entry packs {token, bias_1, bias_2}.
module stage_feed_buf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [3*DATA_W-1:0]      wr_word,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [3*DATA_W-1:0]      rd_word
);

   logic [3*DATA_W-1:0] mem [DEPTH];

   // NOTE: storage has no reset; contents are only meaningful once loaded, and leaving them unreset keeps this a plain register file.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_word;
   end

   assign rd_word = mem[rd_addr];

endmodule

// File: rtl/stage_stream_feeder.sv
// Plays a preloaded token/bias set into a Stage_2head instance, then holds zeros
// until the stage signals end_s (or a timeout expires) and reports completion.
module stage_stream_feeder
   import stage_stream_feeder_pkg::*;
#(
   parameter int DATA_W  = att_width,
   parameter int DEPTH   = FEED_DEPTH,
   parameter int TIMEOUT = FEED_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DATA_W-1:0]        wr_bias_1,
   input  logic [DATA_W-1:0]        wr_bias_2,
   input  logic                     start,
   input  logic [$clog2(DEPTH):0]   len,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout_err,
   output logic                     en,
   output logic [DATA_W-1:0]        i_stage,
   output logic [DATA_W-1:0]        bias_1,
   output logic [DATA_W-1:0]        bias_2,
   input  logic                     end_s
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   feeder_state_t     state_q, state_d;
   logic [LW-1:0]     len_q, len_d, idx_q, idx_d;
   logic [TW-1:0]     wait_q, wait_d;
   logic              end_seen_q, end_seen_d;
   logic              en_d, done_d, err_d;
   logic [DATA_W-1:0] tok_d, b1_d, b2_d;
   logic              buf_we;
   logic [AW-1:0]     rd_addr;
   logic [DATA_W-1:0] rd_tok, rd_b1, rd_b2;

   // The first token is fetched during the start cycle, so the read index is 0 in IDLE.
   assign rd_addr = (state_q == IDLE) ? '0 : idx_q[AW-1:0];
   assign buf_we  = wr_en && (state_q == IDLE) && !start;

   stage_feed_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_addr (wr_addr),
      .wr_word ({wr_data, wr_bias_1, wr_bias_2}),
      .rd_addr (rd_addr),
      .rd_word ({rd_tok, rd_b1, rd_b2})
   );

   // NOTE: every signal written here gets a default first so no latch can be inferred.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      wait_d     = wait_q;
      end_seen_d = end_seen_q;
      en_d       = en;
      done_d     = 1'b0;
      err_d      = timeout_err;
      tok_d      = i_stage;
      b1_d       = bias_1;
      b2_d       = bias_2;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               err_d      = 1'b0;
               end_seen_d = 1'b0;
               wait_d     = '0;
               if (len == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = STREAM;
                  len_d   = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
                  idx_d   = LW'(1);
                  en_d    = 1'b1;
                  tok_d   = rd_tok;
                  b1_d    = rd_b1;
                  b2_d    = rd_b2;
               end
            end
         end
         STREAM: begin
            if (end_s) end_seen_d = 1'b1;
            if (idx_q < len_q) begin
               idx_d = idx_q + LW'(1);
               tok_d = rd_tok;
               b1_d  = rd_b1;
               b2_d  = rd_b2;
            end else begin
               state_d = WAIT_END;
               tok_d   = '0;
               b1_d    = '0;
               b2_d    = '0;
            end
         end
         WAIT_END: begin
            if (end_s || end_seen_q || wait_q == TW'(TIMEOUT - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               en_d    = 1'b0;
               err_d   = !(end_s || end_seen_q);
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end
         DONE: begin
            state_d    = IDLE;
            end_seen_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         wait_q      <= '0;
         end_seen_q  <= 1'b0;
         en          <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         i_stage     <= '0;
         bias_1      <= '0;
         bias_2      <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         wait_q      <= wait_d;
         end_seen_q  <= end_seen_d;
         en          <= en_d;
         done        <= done_d;
         timeout_err <= err_d;
         i_stage     <= tok_d;
         bias_1      <= b1_d;
         bias_2      <= b2_d;
      end
   end

   assign busy = (state_q == STREAM) || (state_q == WAIT_END);

endmodule

// File: tb/tb_stage_stream_feeder.sv
// Directed and randomized checks of stage_stream_feeder against a cycle-indexed
// expectation derived from the run rules (token k at T+1+k, done after end_s/timeout).
module tb_stage_stream_feeder;
   import stage_stream_feeder_pkg::*;

   localparam int DW  = att_width;
   localparam int DEP = 16;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_en = 1'b0;
   logic [3:0]    wr_addr = '0;
   logic [DW-1:0] wr_data = '0, wr_bias_1 = '0, wr_bias_2 = '0;
   logic          start = 1'b0;
   logic [4:0]    len = '0;
   logic          end_s = 1'b0;
   logic          busy, done, timeout_err, en;
   logic [DW-1:0] i_stage, bias_1, bias_2;

   logic [DW-1:0] m_tok [DEP];
   logic [DW-1:0] m_b1  [DEP];
   logic [DW-1:0] m_b2  [DEP];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stage_stream_feeder #(.DATA_W(DW), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_bias_1(wr_bias_1), .wr_bias_2(wr_bias_2), .start(start), .len(len),
      .busy(busy), .done(done), .timeout_err(timeout_err), .en(en),
      .i_stage(i_stage), .bias_1(bias_1), .bias_2(bias_2), .end_s(end_s)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input logic err_exp);
      check({tag, " en"}, 64'(en), 64'(0));
      check({tag, " busy"}, 64'(busy), 64'(0));
      check({tag, " done"}, 64'(done), 64'(0));
      check({tag, " i_stage"}, 64'(i_stage), 64'(0));
      check({tag, " bias_1"}, 64'(bias_1), 64'(0));
      check({tag, " bias_2"}, 64'(bias_2), 64'(0));
      check({tag, " timeout_err"}, 64'(timeout_err), 64'(err_exp));
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic load(input int a, input logic [DW-1:0] d, b1, b2);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = d; wr_bias_1 = b1; wr_bias_2 = b2;
      m_tok[a] = d; m_b1[a] = b1; m_b2[a] = b2;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Starts a run at the next edge T and checks every cycle through T+D+1.
   // end_at: edge offset (from T) carrying a one-cycle end_s pulse, or -1 for none.
   // stray: issue a write in the start cycle and a start+write mid-run, both to be ignored.
   task automatic run(input string tag, input int len_in, input int end_at, input bit stray);
      int  l, d;
      bit  err_exp;
      logic [DW-1:0] e_tok, e_b1, e_b2;
      err_exp = 1'b0;
      l = (len_in > DEP) ? DEP : len_in;
      if (l == 0)                                d = 1;
      else if (end_at >= 1 && end_at <= l + 1)   d = l + 2;
      else if (end_at > l && end_at <= l + TMO)  d = end_at + 1;
      else begin d = l + TMO + 1; err_exp = 1'b1; end
      start = 1'b1; len = 5'(len_in);
      if (stray) begin
         wr_en = 1'b1; wr_addr = '0; wr_data = DW'($urandom);
         wr_bias_1 = DW'($urandom); wr_bias_2 = DW'($urandom);
      end
      for (int t = 1; t <= d + 1; t++) begin
         @(negedge clk);
         start = 1'b0; wr_en = 1'b0;
         end_s = (t == end_at);
         if (stray && t == 2) begin
            start = 1'b1; len = 5'($urandom_range(1, 16));
            wr_en = 1'b1; wr_addr = 4'($urandom); wr_data = DW'($urandom);
         end
         if (t <= l) begin
            e_tok = m_tok[t-1]; e_b1 = m_b1[t-1]; e_b2 = m_b2[t-1];
         end else begin
            e_tok = '0; e_b1 = '0; e_b2 = '0;
         end
         if (t > d) e_tok = '0;
         check($sformatf("%s t%0d en", tag, t), 64'(en), 64'(t < d));
         check($sformatf("%s t%0d busy", tag, t), 64'(busy), 64'(t < d && l > 0));
         check($sformatf("%s t%0d done", tag, t), 64'(done), 64'(t == d));
         check($sformatf("%s t%0d err", tag, t), 64'(timeout_err), 64'(t >= d ? err_exp : 1'b0));
         check($sformatf("%s t%0d i_stage", tag, t), 64'(i_stage), 64'(e_tok));
         check($sformatf("%s t%0d bias_1", tag, t), 64'(bias_1), 64'(e_b1));
         check($sformatf("%s t%0d bias_2", tag, t), 64'(bias_2), 64'(e_b2));
      end
      start = 1'b0; wr_en = 1'b0; end_s = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int l_r, e_r;
      @(negedge clk); @(negedge clk);
      check_idle("reset", 1'b0);
      rstn = 1'b1;
      @(negedge clk);
      check_idle("post_reset", 1'b0);

      // Directed four-token run with a late end_s.
      load(0, 16'd1, 16'd4, 16'd4);
      load(1, 16'd2, 16'd5, 16'd5);
      load(2, 16'd3, 16'd6, 16'd6);
      load(3, 16'd4, 16'd7, 16'd7);
      for (int a = 4; a < DEP; a++) load(a, DW'($urandom), DW'($urandom), DW'($urandom));
      run("t1", 4, 20, 1'b0);

      // Timeout, sticky error, then cleared by the next start.
      run("t2_to", 2, -1, 1'b0);
      @(negedge clk);
      check("t2 sticky err", 64'(timeout_err), 64'(1));
      run("t2_clr", 2, 5, 1'b0);

      // Zero-length run; end_s in IDLE ignored beforehand.
      end_s = 1'b1;
      @(negedge clk);
      end_s = 1'b0;
      check_idle("idle_end_s", 1'b0);
      run("t3", 0, -1, 1'b0);

      // end_s during streaming latches and shortens WAIT_END.
      run("t4", 4, 2, 1'b0);

      // Stray start/write during the run, then an unchanged replay.
      run("t5a", 4, 9, 1'b1);
      run("t5b", 4, 7, 1'b0);

      // Length clamp.
      run("clamp", 25, 30, 1'b0);

      // Reset mid-stream aborts without done; restart replays from entry 0.
      start = 1'b1; len = 5'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check_idle("t6_rst", 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("t6 nodone%0d", i), 64'(done), 64'(0));
      end
      run("t6_replay", 4, 6, 1'b0);

      // Randomized buffer contents, lengths and end_s placement.
      for (int it = 0; it < 20; it++) begin
         for (int a = 0; a < DEP; a++) load(a, DW'($urandom), DW'($urandom), DW'($urandom));
         l_r = $urandom_range(0, 31);
         e_r = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, 16 + TMO + 3);
         run($sformatf("rnd%0d", it), l_r, e_r, bit'($urandom_range(0, 1)) && (l_r >= 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
